// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, state type and lane helper for the FC bias-add stage
package fc_pkg;
    localparam int DATA_WIDTH   = 16;
    localparam int OUTPUT_NODES = 10;
    localparam int NUM_BANKS    = 4;
    localparam int ADDR_WIDTH   = 6;
    localparam int BANK_W       = $clog2(NUM_BANKS);
    localparam int K_W          = $clog2(OUTPUT_NODES + 1);
    localparam int VEC_W        = DATA_WIDTH * OUTPUT_NODES;
    localparam logic [DATA_WIDTH-1:0] FX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] FX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, ADD, HOLD} state_e;

    function automatic logic [DATA_WIDTH-1:0] lane(input logic [VEC_W-1:0] v, input int i);
        return v[DATA_WIDTH*i +: DATA_WIDTH];
    endfunction
endpackage

// File: rtl/fc_bias_sequencer_if.sv
// fc_bias_sequencer_if: input vector handshake, bias memory read port and output handshake
//   slave  = the sequencer, master = its environment
interface fc_bias_sequencer_if;
    import fc_pkg::*;
    logic                    in_valid;
    logic                    in_ready;
    logic [VEC_W-1:0]        fc_in;
    logic [BANK_W-1:0]       bank_sel;
    logic                    bias_rd_en;
    logic [ADDR_WIDTH-1:0]   bias_rd_addr;
    logic [DATA_WIDTH-1:0]   bias_rd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [VEC_W-1:0]        cnn_out;
    logic [OUTPUT_NODES-1:0] sat_flags;

    modport slave (
        input  in_valid, fc_in, bank_sel, bias_rd_data, out_ready,
        output in_ready, bias_rd_en, bias_rd_addr, out_valid, cnn_out, sat_flags
    );
    modport master (
        output in_valid, fc_in, bank_sel, bias_rd_data, out_ready,
        input  in_ready, bias_rd_en, bias_rd_addr, out_valid, cnn_out, sat_flags
    );
endinterface

// File: rtl/fc_sat_add.sv
// fc_sat_add: one-lane signed saturating adder
//   a, b   : signed lane operands
//   result : a+b clamped to the lane range
//   sat    : high when result was clamped
module fc_sat_add
    import fc_pkg::*;
(
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         sat
);
    logic signed [DATA_WIDTH:0] sum;
    assign sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    // overflow iff the extra sign bit disagrees with the lane sign bit
    assign sat = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
    assign result = !sat ? sum[DATA_WIDTH-1:0] : sum[DATA_WIDTH] ? FX_MIN : FX_MAX;
endmodule

// File: rtl/fc_bias_sequencer.sv
// fc_bias_sequencer: caches a bias bank from external memory and adds it lane-wise with saturation
//   clk, reset : clock, synchronous active-high reset
//   io         : input vector handshake, bias memory read port, registered output handshake
module fc_bias_sequencer
    import fc_pkg::*;
(
    input logic                clk,
    input logic                reset,
    fc_bias_sequencer_if.slave io
);
    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [VEC_W-1:0]        fc_q, cnn_out_q, sum_w;
    logic [BANK_W-1:0]       bank_q, cached_bank_q, bank_norm;
    logic                    cache_valid_q;
    logic [DATA_WIDTH-1:0]   cache_q [OUTPUT_NODES];
    logic [OUTPUT_NODES-1:0] sat_q, sat_w;
    logic                    accept, hit, rd_en, load_last;

    assign bank_norm = 32'(io.bank_sel) < NUM_BANKS ? io.bank_sel : '0;
    assign accept    = io.in_valid && io.in_ready;
    assign hit       = cache_valid_q && cached_bank_q == bank_norm;
    // LOAD runs one cycle past the last read to capture its data
    assign load_last = k_q == K_W'(OUTPUT_NODES);
    assign rd_en     = state_q == LOAD && !load_last;

    assign io.in_ready     = state_q == IDLE && !reset;
    assign io.bias_rd_en   = rd_en;
    assign io.bias_rd_addr = rd_en ? ADDR_WIDTH'(int'(bank_q) * OUTPUT_NODES + int'(k_q)) : '0;
    assign io.out_valid    = state_q == HOLD;
    assign io.cnn_out      = cnn_out_q;
    assign io.sat_flags    = sat_q;

    always_comb begin
        state_d = state_q;
        k_d     = '0;
        case (state_q)
            IDLE: state_d = accept ? (hit ? ADD : LOAD) : IDLE;
            LOAD: begin
                k_d     = k_q + K_W'(1);
                state_d = load_last ? ADD : LOAD;
            end
            ADD:  state_d = HOLD;
            HOLD: state_d = io.out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            fc_q          <= '0;
            bank_q        <= '0;
            cached_bank_q <= '0;
            cache_valid_q <= 1'b0;
            cnn_out_q     <= '0;
            sat_q         <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                fc_q   <= io.fc_in;
                bank_q <= bank_norm;
            end
            // a fill in progress is never trusted until it completes
            if (accept && !hit)
                cache_valid_q <= 1'b0;
            if (state_q == LOAD && load_last) begin
                cache_valid_q <= 1'b1;
                cached_bank_q <= bank_q;
            end
            if (state_q == ADD) begin
                cnn_out_q <= sum_w;
                sat_q     <= sat_w;
            end
        end
    end

    // read data arrives one cycle after its strobe, so cycle k stores lane k-1
    always_ff @(posedge clk) begin
        if (!reset && state_q == LOAD && k_q != '0)
            cache_q[k_q - K_W'(1)] <= io.bias_rd_data;
    end

    for (genvar g = 0; g < OUTPUT_NODES; g++) begin : g_lane
        fc_sat_add u_add (
            .a      (lane(fc_q, g)),
            .b      (cache_q[g]),
            .result (sum_w[DATA_WIDTH*g +: DATA_WIDTH]),
            .sat    (sat_w[g])
        );
    end
endmodule

// File: tb/tb_fc_bias_sequencer.sv
// tb_fc_bias_sequencer: directed vector table plus backpressure and reset-abort sequences
module tb_fc_bias_sequencer;
    import fc_pkg::*;
    localparam int N  = OUTPUT_NODES;
    localparam int DW = DATA_WIDTH;
    localparam int VW = DW * N;

    typedef struct {
        logic [BANK_W-1:0] bank;
        logic [VW-1:0]     fc;
        bit                miss;
    } vec_t;

    logic clk, reset;
    fc_bias_sequencer_if bus();
    fc_bias_sequencer dut (.clk(clk), .reset(reset), .io(bus));

    logic [DW-1:0]         mem [64];
    logic [ADDR_WIDTH-1:0] rd_log [$];
    vec_t                  tv [7];
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.bias_rd_en) bus.bias_rd_data <= mem[bus.bias_rd_addr];
    always @(negedge clk) if (bus.bias_rd_en) rd_log.push_back(bus.bias_rd_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [BANK_W-1:0] b, input logic [VW-1:0] fc,
                                  output logic [VW-1:0] o, output logic [N-1:0] s);
        o = '0;
        s = '0;
        for (int i = 0; i < N; i++) begin
            int x;
            x = int'($signed(fc[DW*i +: DW])) + int'($signed(mem[int'(b) * N + i]));
            if (x > 32767) begin
                o[DW*i +: DW] = 16'h7FFF;
                s[i] = 1'b1;
            end else if (x < -32768) begin
                o[DW*i +: DW] = 16'h8000;
                s[i] = 1'b1;
            end else
                o[DW*i +: DW] = DW'(x);
        end
    endfunction

    task automatic release_out;
        @(negedge clk) bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [BANK_W-1:0] b, input logic [VW-1:0] fc, output int waits, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.fc_in    = fc;
        bus.bank_sel = b;
        rd_log.delete();
        waits = 0;
        while (!bus.in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        lat = 1;
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_txn(input string tag, input logic [BANK_W-1:0] b, input logic [VW-1:0] fc,
                             input bit miss, input int lat);
        logic [VW-1:0] eo;
        logic [N-1:0]  es;
        bit ok;
        model(b, fc, eo, es);
        check({tag, "_latency"}, VW'(lat), VW'(miss ? 13 : 2));
        check({tag, "_cnn_out"}, bus.cnn_out, eo);
        check({tag, "_sat"}, VW'(bus.sat_flags), VW'(es));
        check({tag, "_in_ready_hold"}, VW'(bus.in_ready), '0);
        check({tag, "_reads"}, VW'(rd_log.size()), VW'(miss ? N : 0));
        ok = 1'b1;
        foreach (rd_log[i]) if (int'(rd_log[i]) != int'(b) * N + i) ok = 1'b0;
        check({tag, "_addrs"}, VW'(ok), VW'(1));
    endtask

    initial begin
        int waits, lat;
        logic [VW-1:0] snap, fcb;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.fc_in    = '0;
        bus.bank_sel = '0;
        foreach (mem[a]) mem[a] = '0;
        for (int i = 0; i < N; i++) begin
            mem[i]          = 16'd5;
            mem[N + i]      = DW'(100 + i);
            mem[2 * N + i]  = DW'(-3 * (i + 1));
            mem[3 * N + i]  = 16'h7000;
        end
        mem[0] = 16'h0100;
        mem[1] = 16'hFF00;

        tv[0].bank = 1; tv[0].miss = 1;
        tv[1].bank = 1; tv[1].miss = 0; tv[1].fc = '0;
        tv[2].bank = 2; tv[2].miss = 1;
        tv[3].bank = 0; tv[3].miss = 1;
        tv[4].bank = 3; tv[4].miss = 1;
        tv[5].bank = 3; tv[5].miss = 0;
        tv[6].bank = 3; tv[6].miss = 0;
        for (int i = 0; i < N; i++) begin
            tv[0].fc[DW*i +: DW] = DW'(i);
            tv[2].fc[DW*i +: DW] = DW'(1000 * i);
            tv[3].fc[DW*i +: DW] = DW'(i);
            tv[4].fc[DW*i +: DW] = 16'h1000 + DW'(i);
            tv[5].fc[DW*i +: DW] = 16'h9000;
            tv[6].fc[DW*i +: DW] = 16'h8000;
        end
        tv[3].fc[0 +: DW]  = 16'h7FF0;
        tv[3].fc[DW +: DW] = 16'h8005;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", VW'(bus.in_ready), '0);
        check("rst_out_valid", VW'(bus.out_valid), '0);
        check("rst_rd_en", VW'(bus.bias_rd_en), '0);
        check("rst_rd_addr", VW'(bus.bias_rd_addr), '0);
        check("rst_cnn_out", bus.cnn_out, '0);
        check("rst_sat", VW'(bus.sat_flags), '0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", VW'(bus.in_ready), VW'(1));

        for (int t = 0; t < 7; t++) begin
            run_txn(tv[t].bank, tv[t].fc, waits, lat);
            check_txn($sformatf("vec%0d", t), tv[t].bank, tv[t].fc, tv[t].miss, lat);
            if (t == 0) check("vec0_lane3", VW'(bus.cnn_out[DW*3 +: DW]), VW'(16'd106));
            if (t == 3) begin
                check("vec3_lane0", VW'(bus.cnn_out[0 +: DW]), VW'(16'h7FFF));
                check("vec3_lane1", VW'(bus.cnn_out[DW +: DW]), VW'(16'h8000));
                check("vec3_sat", VW'(bus.sat_flags), VW'(10'b0000000011));
            end
            if (t == 4) check("vec4_sat", VW'(bus.sat_flags), VW'(10'h3FF));
            if (t == 6) check("vec6_lane0", VW'(bus.cnn_out[0 +: DW]), VW'(16'hF000));
            release_out();
        end

        run_txn(3, tv[2].fc, waits, lat);
        check_txn("bp_first", 3, tv[2].fc, 1'b0, lat);
        snap = bus.cnn_out;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_stable%0d", c), bus.cnn_out, snap);
            check($sformatf("bp_in_ready%0d", c), VW'(bus.in_ready), '0);
            check($sformatf("bp_out_valid%0d", c), VW'(bus.out_valid), VW'(1));
        end
        for (int i = 0; i < N; i++) fcb[DW*i +: DW] = DW'(7 * i - 20);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.fc_in     = fcb;
        bus.bank_sel  = 3;
        check("bp_no_accept_in_hold", VW'(bus.in_ready), '0);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        run_txn(3, fcb, waits, lat);
        check("bp_accept_next_cycle", VW'(waits), '0);
        check_txn("bp_second", 3, fcb, 1'b0, lat);
        release_out();

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.fc_in    = tv[0].fc;
        bus.bank_sel = 1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_rd_en", VW'(bus.bias_rd_en), VW'(1));
        check("abort_rd_addr", VW'(bus.bias_rd_addr), VW'(14));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", VW'(bus.out_valid), '0);
        check("abort_rd_en_off", VW'(bus.bias_rd_en), '0);
        run_txn(1, tv[0].fc, waits, lat);
        check_txn("abort_reload", 1, tv[0].fc, 1'b1, lat);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
